// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
//   A round-robin scheduler that shares one 4-bit ALU among NREQ requesters.
//   On each cycle the response slot is free, it grants one valid requester. The
//   granted operands drive the shared ALU. The result is registered into a
//   single-entry response slot, tagged with the index of the winning requester.
//   When the slot drains and a new request is accepted in the same cycle, the
//   scheduler sustains one operation per cycle.
//
// Optional feature (compile-time macro ALU_RR_SCHED_STATS_EN):
//   Adds output acc_cnt_o, a 16-bit saturating count of accepted requests.
//
// ALU opcodes (req_sel):
//   000 add  {cout,res} = a + b + cin
//   001 sub  {cout,res} = a - b - cin   (5-bit, wraps modulo 32)
//   010 and  011 or  100 xor  101 not(a)   -- cout forced to 0
//   110 shl  res = a << 1, cout = a[3]
//   111 shr  res = a >> 1, cout = a[0]
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid_i   [NREQ]    per-requester request valid
//   req_ready_o   [NREQ]    per-requester accept (one-hot or zero)
//   req_sel_i     [3*NREQ]  opcode, slice i = [3i+2:3i]
//   req_a_i       [4*NREQ]  operand A, slice i = [4i+3:4i]
//   req_b_i       [4*NREQ]  operand B, slice i = [4i+3:4i]
//   req_cin_i     [NREQ]    carry/borrow-in
//   rsp_valid_o             response slot full
//   rsp_ready_i             consumer accepts the response
//   rsp_id_o      [IDW]     index of the requester that produced the response
//   rsp_result_o  [4]       registered ALU result
//   rsp_cout_o              registered ALU carry/shift-out
//   acc_cnt_o     [16]      accept counter (only with ALU_RR_SCHED_STATS_EN)
// -----------------------------------------------------------------------------

// Shared 4-bit combinational ALU.
module alu4 (
  input  logic [2:0] sel_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] result_o,
  output logic       cout_o
);
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  logic [4:0] sum;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    sum = 5'd0;
    case (alu_op_e'(sel_i))
      OP_ADD: sum = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
      // 5-bit subtraction wraps naturally, so a borrow shows up in sum[4].
      OP_SUB: sum = {1'b0, a_i} - {1'b0, b_i} - {4'd0, cin_i};
      OP_AND: sum = {1'b0, a_i & b_i};
      OP_OR:  sum = {1'b0, a_i | b_i};
      OP_XOR: sum = {1'b0, a_i ^ b_i};
      OP_NOT: sum = {1'b0, ~a_i};
      OP_SHL: sum = {a_i[3], a_i[2:0], 1'b0};
      OP_SHR: sum = {a_i[0], 1'b0, a_i[3:1]};
      default: sum = 5'd0;
    endcase
  end

  assign result_o = sum[3:0];
  assign cout_o   = sum[4];
endmodule

module alu_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [3*NREQ-1:0] req_sel_i,
  input  logic [4*NREQ-1:0] req_a_i,
  input  logic [4*NREQ-1:0] req_b_i,
  input  logic [NREQ-1:0]   req_cin_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [3:0]        rsp_result_o,
  output logic              rsp_cout_o
`ifdef ALU_RR_SCHED_STATS_EN
  ,
  output logic [15:0]       acc_cnt_o
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] rsp_id_q;
  logic [3:0]     rsp_result_q;
  logic           rsp_cout_q;

  logic           slot_free;
  logic           hi_found;
  logic           lo_found;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;
  logic [IDW-1:0] win_idx;
  logic           grant_en;
  logic           accept;
  logic [IDW-1:0] ptr_d;

  logic [2:0]     op_sel;
  logic [3:0]     op_a;
  logic [3:0]     op_b;
  logic           op_cin;
  logic [3:0]     alu_result;
  logic           alu_cout;

  assign slot_free = (state_q == EMPTY) || rsp_ready_i;

  // Round-robin search without a rotator. hi_* holds the lowest valid index
  // at or above ptr, and lo_* holds the lowest valid index overall. When no
  // valid index exists at or above ptr, the search wraps around to lo_*.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        if (IDW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
  end

  assign win_idx  = hi_found ? hi_idx : lo_idx;
  // Gating with rst_n keeps every ready low while reset is held.
  assign grant_en = rst_n && slot_free && lo_found;

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = grant_en && (win_idx == IDW'(i));
    end
  end

  assign accept = |(req_ready_o & req_valid_i);
  assign ptr_d  = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);

  // Operand mux: only the winner's slices reach the shared ALU.
  always_comb begin
    op_sel = '0;
    op_a   = '0;
    op_b   = '0;
    op_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        op_sel = req_sel_i[3*i +: 3];
        op_a   = req_a_i[4*i +: 4];
        op_b   = req_b_i[4*i +: 4];
        op_cin = req_cin_i[i];
      end
    end
  end

  alu4 u_alu (
    .sel_i    (op_sel),
    .a_i      (op_a),
    .b_i      (op_b),
    .cin_i    (op_cin),
    .result_o (alu_result),
    .cout_o   (alu_cout)
  );

  // Response slot FSM. An accept always loads the slot and leaves it FULL,
  // whether the slot was EMPTY or was draining in the same cycle. When the
  // slot drains with no accept, the response registers keep their old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      ptr_q        <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples pre-edge values.
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= FULL;
          end
        end
        FULL: begin
          if (!accept && rsp_ready_i) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        ptr_q        <= ptr_d;
        rsp_id_q     <= win_idx;
        rsp_result_q <= alu_result;
        rsp_cout_q   <= alu_cout;
      end
    end
  end

  assign rsp_valid_o  = (state_q == FULL);
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_cout_o   = rsp_cout_q;

`ifdef ALU_RR_SCHED_STATS_EN
  logic [15:0] acc_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
    end else if (accept && (acc_cnt_q != 16'hFFFF)) begin
      acc_cnt_q <= acc_cnt_q + 16'd1;
    end
  end

  assign acc_cnt_o = acc_cnt_q;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_scheduler
//   Self-checking bench for alu_rr_scheduler (NREQ = 4).
//   The reference model keeps the rotation pointer, the slot occupancy and the
//   last response as plain integers. It picks the winner by scanning
//   (ptr + k) mod NREQ, and it computes ALU results with integer arithmetic.
//   Define ALU_RR_SCHED_STATS_EN to also exercise the accept counter.
// -----------------------------------------------------------------------------
module tb_alu_rr_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_sel = '0;
  logic [4*NREQ-1:0] req_a = '0;
  logic [4*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_cin = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_result;
  logic              rsp_cout;
`ifdef ALU_RR_SCHED_STATS_EN
  logic [15:0]       acc_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int m_ptr, m_id, m_res, m_cout, m_acc;
  bit m_full;

  // Values captured by run_cycle, used by the hand-written sequences.
  logic [NREQ-1:0] g_ready;
  logic            g_vld;
  int              g_acc_w;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] res;
    logic       cout;
  } vec_t;

  vec_t vecs[13];

  alu_rr_scheduler #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_sel_i    (req_sel),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_cin_i    (req_cin),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_cout_o   (rsp_cout)
`ifdef ALU_RR_SCHED_STATS_EN
    ,
    .acc_cnt_o    (acc_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ALU behaviour as a 5-bit value {cout, result}.
  function automatic int alu_ref(input int sel, input int a, input int b, input int cin);
    int s;
    case (sel)
      0: s = a + b + cin;
      1: s = (a - b - cin + 32) % 32;
      2: s = a & b;
      3: s = a | b;
      4: s = a ^ b;
      5: s = (~a) & 15;
      6: s = ((a * 2) % 16) + ((a / 8) % 2) * 16;
      default: s = (a / 2) + (a % 2) * 16;
    endcase
    return s;
  endfunction

  function automatic void model_reset();
    m_ptr  = 0;
    m_full = 1'b0;
    m_id   = 0;
    m_res  = 0;
    m_cout = 0;
    m_acc  = 0;
  endfunction

  task automatic set_req(input int i, input int sel, input int a, input int b, input int cin);
    req_sel[3*i +: 3] = 3'(sel);
    req_a[4*i +: 4]   = 4'(a);
    req_b[4*i +: 4]   = 4'(b);
    req_cin[i]        = 1'(cin);
    req_valid[i]      = 1'b1;
  endtask

  // Entered just after a falling edge, with the inputs already applied.
  // Checks the outputs against the model, crosses one rising edge, updates
  // the model, and returns just after the next falling edge.
  task automatic run_cycle(input string tag);
    logic [NREQ-1:0] exp_ready;
    int w, sel, a, b, cin, s;
    bit free_slot;
    #1;
    exp_ready = '0;
    w = -1;
    sel = 0; a = 0; b = 0; cin = 0;
    free_slot = !m_full || (rsp_ready === 1'b1);
    if (free_slot) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && req_valid[idx] === 1'b1) w = idx;
      end
    end
    if (w >= 0) begin
      exp_ready[w] = 1'b1;
      sel = int'(req_sel[3*w +: 3]);
      a   = int'(req_a[4*w +: 4]);
      b   = int'(req_b[4*w +: 4]);
      cin = int'(req_cin[w]);
    end
    g_ready = req_ready;
    g_vld   = rsp_valid;
    check({tag, ":req_ready"}, 32'(req_ready), 32'(exp_ready));
    check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(m_full));
    check({tag, ":rsp_id"}, 32'(rsp_id), m_id);
    check({tag, ":rsp_result"}, 32'(rsp_result), m_res);
    check({tag, ":rsp_cout"}, 32'(rsp_cout), m_cout);
    @(posedge clk);
    if (w >= 0) begin
      s      = alu_ref(sel, a, b, cin);
      m_res  = s % 16;
      m_cout = s / 16;
      m_id   = w;
      m_full = 1'b1;
      m_ptr  = (w + 1) % NREQ;
      if (m_acc < 65535) m_acc++;
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
    g_acc_w = w;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    check("reset:req_ready", 32'(req_ready), 32'd0);
    check("reset:rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset:rsp_result", 32'(rsp_result), 32'd0);
    check("reset:rsp_cout", 32'(rsp_cout), 32'd0);
    check("reset:rsp_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    //            sel     a     b     cin   res   cout
    vecs[0]  = '{3'b000, 4'h9, 4'h8, 1'b1, 4'h2, 1'b1};
    vecs[1]  = '{3'b000, 4'h1, 4'h2, 1'b0, 4'h3, 1'b0};
    vecs[2]  = '{3'b000, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[3]  = '{3'b001, 4'h3, 4'h5, 1'b0, 4'hE, 1'b1};
    vecs[4]  = '{3'b001, 4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    vecs[5]  = '{3'b001, 4'h9, 4'h4, 1'b1, 4'h4, 1'b0};
    vecs[6]  = '{3'b010, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0};
    vecs[7]  = '{3'b011, 4'h5, 4'hA, 1'b0, 4'hF, 1'b0};
    vecs[8]  = '{3'b100, 4'hF, 4'h3, 1'b0, 4'hC, 1'b0};
    vecs[9]  = '{3'b101, 4'h6, 4'h0, 1'b0, 4'h9, 1'b0};
    vecs[10] = '{3'b110, 4'hA, 4'h0, 1'b0, 4'h4, 1'b1};
    vecs[11] = '{3'b111, 4'h5, 4'h0, 1'b0, 4'h2, 1'b1};
    vecs[12] = '{3'b110, 4'h3, 4'h0, 1'b1, 4'h6, 1'b0};

    apply_reset();

    // Table-driven ALU vectors through requester 0, response taken every cycle.
    rsp_ready = 1'b1;
    foreach (vecs[v]) begin
      req_valid = '0;
      set_req(0, int'(vecs[v].sel), int'(vecs[v].a), int'(vecs[v].b), int'(vecs[v].cin));
      run_cycle("vec");
      check("vec:grant0", 32'(g_ready), 32'h1);
      req_valid = '0;
      check("vec:valid", 32'(rsp_valid), 32'd1);
      check("vec:result", 32'(rsp_result), 32'(vecs[v].res));
      check("vec:cout", 32'(rsp_cout), 32'(vecs[v].cout));
      check("vec:id", 32'(rsp_id), 32'd0);
    end
    run_cycle("vec_drain");

    // All requesters held valid: grants rotate 0,1,2,3,0.
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
    end
    for (int k = 0; k < 5; k++) begin
      run_cycle("rr");
      check("rr:grant", 32'(g_ready), 32'(1) << (k % NREQ));
      check("rr:valid", 32'(g_vld), (k != 0) ? 32'd1 : 32'd0);
    end
    req_valid = '0;
    run_cycle("rr_drain");

    // Backpressure while FULL holding sub 3-5 = E with borrow.
    apply_reset();
    rsp_ready = 1'b1;
    set_req(0, 1, 3, 5, 0);
    run_cycle("bp_load");
    req_valid = '0;
    set_req(2, 0, 7, 1, 0);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run_cycle("bp_hold");
      check("bp:no_grant", 32'(g_ready), 32'd0);
      check("bp:result", 32'(rsp_result), 32'hE);
      check("bp:cout", 32'(rsp_cout), 32'd1);
      check("bp:valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    run_cycle("bp_release");
    check("bp:grant2", 32'(g_ready), 32'h4);
    req_valid = '0;
    check("bp:next_result", 32'(rsp_result), 32'h8);
    check("bp:next_id", 32'(rsp_id), 32'd2);
    run_cycle("bp_drain");

    // Mid-stream reset while FULL with ptr = 2.
    apply_reset();
    rsp_ready = 1'b1;
    set_req(1, 0, 1, 1, 0);
    run_cycle("mr_load");
    req_valid = '0;
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mr:valid_async", 32'(rsp_valid), 32'd0);
    check("mr:result_cleared", 32'(rsp_result), 32'd0);
    check("mr:ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(1, 0, 2, 3, 0);
    set_req(3, 2, 4'hF, 4'h6, 0);
    run_cycle("mr_first");
    check("mr:first_grant1", 32'(g_ready), 32'h2);
    req_valid[1] = 1'b0;
    run_cycle("mr_second");
    check("mr:second_grant3", 32'(g_ready), 32'h8);
    req_valid = '0;
    run_cycle("mr_drain");

    // Randomized traffic against the model; requesters hold until accepted.
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] == 1'b0 && $urandom_range(0, 1) == 1) begin
          set_req(i, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
        end
      end
      run_cycle("rand");
      if (g_acc_w >= 0) req_valid[g_acc_w] = 1'b0;
    end
`ifdef ALU_RR_SCHED_STATS_EN
    check("stats:rand_count", 32'(acc_cnt), m_acc);

    // Saturation: 70000 back-to-back accepts.
    apply_reset();
    rsp_ready = 1'b1;
    set_req(0, 0, 1, 1, 0);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("stats:saturate", 32'(acc_cnt), 32'hFFFF);
    repeat (3) @(negedge clk);
    check("stats:hold", 32'(acc_cnt), 32'hFFFF);
    req_valid = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
